sdr_tune_controller: RTL and testbench

Command sequencer between the UART receiver and the SDR datapath (NCO, CIC pair). It decodes received ASCII command bytes into NCO phase-increment and CIC gain updates, with saturating arithmetic on the phase increment. New settings are committed to the datapath only on a CIC output-sample boundary, so the demodulator never sees a mid-sample retune. Each command is acknowledged with one status byte on a ready/valid TX interface.

---
 rtl/sdr_pkg.sv | 39 +++
 rtl/sdr_phase_step.sv | 30 +++
 rtl/sdr_tune_controller.sv | 157 +++++++++++++++
 tb/tb_sdr_tune_controller.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_pkg.sv
// Shared constants and FSM encoding for the SDR tune controller.
// Command bytes, preset/step increments and acknowledgement codes.
package sdr_pkg;

  localparam logic [7:0] CMD_G0 = 8'h30;
  localparam logic [7:0] CMD_G3 = 8'h33;
  localparam logic [7:0] CMD_A  = 8'h61;
  localparam logic [7:0] CMD_B  = 8'h62;
  localparam logic [7:0] CMD_F  = 8'h66;
  localparam logic [7:0] CMD_G  = 8'h67;
  localparam logic [7:0] CMD_M  = 8'h6D;
  localparam logic [7:0] CMD_N  = 8'h6E;
  localparam logic [7:0] CMD_O  = 8'h6F;
  localparam logic [7:0] CMD_P  = 8'h70;
  localparam logic [7:0] CMD_Q  = 8'h71;
  localparam logic [7:0] CMD_R  = 8'h72;

  localparam logic [63:0] PRESET_A = 64'h04CF_41F2_12D7_7318;
  localparam logic [63:0] PRESET_B = 64'h01AA_60F8_B891_1654;
  localparam logic [63:0] PRESET_F = 64'h1DC3_8C07_6704_516D;
  localparam logic [63:0] PRESET_G = 64'h1D60_D923_2954_82C6;

  localparam logic [63:0] STEP_9K  = 64'h0007_1B37_5868_D170;
  localparam logic [63:0] STEP_100 = 64'h0000_1436_A8CD_F6F3;
  localparam logic [63:0] STEP_1K  = 64'h0000_CA22_980B_A57E;

  localparam logic [7:0] ACK_UNKNOWN = 8'h3F;
  localparam logic [7:0] ACK_CLAMP   = 8'h21;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    COMPUTE,
    WAIT_SYNC,
    COMMIT,
    ACK
  } state_t;

endpackage

// File: rtl/sdr_phase_step.sv
// Saturating add/subtract of a tuning step to the NCO increment.
// Result clamps to [0, MAX]; clamp flags that a limit was hit.
module sdr_phase_step #(
  parameter int unsigned W = 64,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic [W-1:0] base,
  input  logic [W-1:0] step,
  input  logic         sub,
  output logic [W-1:0] result,
  output logic         clamp
);

  logic [W:0] sum;

  always_comb begin
    sum    = sub ? ({1'b0, base} - {1'b0, step})
                 : ({1'b0, base} + {1'b0, step});
    result = sum[W-1:0];
    clamp  = 1'b0;
    if (sub && sum[W]) begin
      result = '0;
      clamp  = 1'b1;
    end else if (sum > {1'b0, MAX}) begin
      result = MAX;
      clamp  = 1'b1;
    end
  end

endmodule

// File: rtl/sdr_tune_controller.sv
// UART command sequencer: stages NCO/CIC settings and commits them
// on a CIC sample boundary, acknowledging each command on TX.
module sdr_tune_controller #(
  parameter int unsigned PHASE_WIDTH = 64,
  parameter int unsigned GAIN_WIDTH  = 8,
  parameter logic [PHASE_WIDTH-1:0] PHASE_MAX =
    64'h7FFF_FFFF_FFFF_FFFF,
  parameter logic [PHASE_WIDTH-1:0] RESET_PHASE =
    64'h04CF_41F2_12D7_7318,
  parameter int unsigned SYNC_TIMEOUT = 8192
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_byte,
  input  logic                   sample_strobe,
  output logic [PHASE_WIDTH-1:0] phase_increment,
  output logic [GAIN_WIDTH-1:0]  cic_gain,
  output logic                   update,
  output logic                   busy,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [7:0]             tx_byte,
  output logic [7:0]             drop_count
);

  import sdr_pkg::*;

  localparam int unsigned CW =
    (SYNC_TIMEOUT > 2) ? $clog2(SYNC_TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(SYNC_TIMEOUT - 1);

  state_t state, state_nx;

  logic [7:0]             cmd_q;
  logic [7:0]             ack_q;
  logic [PHASE_WIDTH-1:0] stg_phase;
  logic [GAIN_WIDTH-1:0]  stg_gain;
  logic [CW-1:0]          wait_cnt;

  logic                   known;
  logic                   is_gain;
  logic                   is_step;
  logic                   step_sub;
  logic [PHASE_WIDTH-1:0] step;
  logic [PHASE_WIDTH-1:0] preset;
  logic [PHASE_WIDTH-1:0] step_res;
  logic                   step_clamp;
  logic [PHASE_WIDTH-1:0] nx_phase;

  always_comb begin
    known    = 1'b1;
    is_gain  = 1'b0;
    is_step  = 1'b0;
    step_sub = 1'b0;
    step     = '0;
    preset   = stg_phase;
    unique case (1'b1)
      (cmd_q >= CMD_G0 && cmd_q <= CMD_G3): is_gain = 1'b1;
      (cmd_q == CMD_A): preset = PHASE_WIDTH'(PRESET_A);
      (cmd_q == CMD_B): preset = PHASE_WIDTH'(PRESET_B);
      (cmd_q == CMD_F): preset = PHASE_WIDTH'(PRESET_F);
      (cmd_q == CMD_G): preset = PHASE_WIDTH'(PRESET_G);
      (cmd_q == CMD_N): begin
        is_step = 1'b1; step_sub = 1'b1;
        step = PHASE_WIDTH'(STEP_9K);
      end
      (cmd_q == CMD_M): begin
        is_step = 1'b1; step = PHASE_WIDTH'(STEP_9K);
      end
      (cmd_q == CMD_O): begin
        is_step = 1'b1; step_sub = 1'b1;
        step = PHASE_WIDTH'(STEP_100);
      end
      (cmd_q == CMD_P): begin
        is_step = 1'b1; step = PHASE_WIDTH'(STEP_100);
      end
      (cmd_q == CMD_Q): begin
        is_step = 1'b1; step_sub = 1'b1;
        step = PHASE_WIDTH'(STEP_1K);
      end
      (cmd_q == CMD_R): begin
        is_step = 1'b1; step = PHASE_WIDTH'(STEP_1K);
      end
      default: known = 1'b0;
    endcase
  end

  sdr_phase_step #(
    .W   (PHASE_WIDTH),
    .MAX (PHASE_MAX)
  ) u_step (
    .base   (stg_phase),
    .step   (step),
    .sub    (step_sub),
    .result (step_res),
    .clamp  (step_clamp)
  );

  assign nx_phase = is_step ? step_res : preset;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (rx_valid) state_nx = DECODE;
      DECODE:    state_nx = known ? COMPUTE : ACK;
      COMPUTE:   state_nx = WAIT_SYNC;
      WAIT_SYNC: if (sample_strobe || wait_cnt == WAIT_LAST)
                   state_nx = COMMIT;
      COMMIT:    state_nx = ACK;
      ACK:       if (tx_ready) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state           <= IDLE;
      cmd_q           <= '0;
      ack_q           <= '0;
      stg_phase       <= RESET_PHASE;
      stg_gain        <= '0;
      wait_cnt        <= '0;
      phase_increment <= RESET_PHASE;
      cic_gain        <= '0;
      drop_count      <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && rx_valid)
        cmd_q <= rx_byte;
      if (state != IDLE && rx_valid && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
      if (state == DECODE && !known)
        ack_q <= ACK_UNKNOWN;
      if (state == COMPUTE) begin
        ack_q <= (is_step && step_clamp) ? ACK_CLAMP : cmd_q;
        if (is_gain) stg_gain <= GAIN_WIDTH'(cmd_q[1:0]);
        else         stg_phase <= nx_phase;
      end
      // Counter runs only while parked in WAIT_SYNC
      if (state == WAIT_SYNC && state_nx == WAIT_SYNC)
        wait_cnt <= wait_cnt + CW'(1);
      else
        wait_cnt <= '0;
      if (state == WAIT_SYNC && state_nx == COMMIT) begin
        phase_increment <= stg_phase;
        cic_gain        <= stg_gain;
      end
    end
  end

  assign update   = (state == COMMIT);
  assign busy     = (state != IDLE);
  assign tx_valid = (state == ACK);
  assign tx_byte  = ack_q;

endmodule

// File: tb/tb_sdr_tune_controller.sv
// Randomised self-checking bench for sdr_tune_controller against
// an arithmetic model of the command set and commit timing.
module tb_sdr_tune_controller;

  localparam logic [63:0] RST_PH = 64'h04CF_41F2_12D7_7318;
  localparam logic [63:0] PH_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam int TIMEOUT = 8192;

  logic        clk;
  logic        arst_n;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        sample_strobe;
  logic [63:0] phase_increment;
  logic [7:0]  cic_gain;
  logic        update;
  logic        busy;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_byte;
  logic [7:0]  drop_count;

  sdr_tune_controller dut (
    .clk             (clk),
    .arst_n          (arst_n),
    .rx_valid        (rx_valid),
    .rx_byte         (rx_byte),
    .sample_strobe   (sample_strobe),
    .phase_increment (phase_increment),
    .cic_gain        (cic_gain),
    .update          (update),
    .busy            (busy),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .tx_byte         (tx_byte),
    .drop_count      (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  int upd_cnt = 0;

  logic [63:0] m_phase;
  logic [7:0]  m_gain;
  int          m_drops;

  always @(negedge clk) if (update === 1'b1) upd_cnt++;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] drops_sat();
    return (m_drops > 255) ? 8'hFF : 8'(m_drops);
  endfunction

  task automatic model(input logic [7:0] b, output bit kn,
                       output logic [7:0] ea);
    logic signed [66:0] d;
    logic signed [66:0] v;
    kn = 1'b1;
    ea = b;
    d  = '0;
    case (b)
      "0", "1", "2", "3": m_gain = b - 8'h30;
      "a": m_phase = 64'h04CF41F212D77318;
      "b": m_phase = 64'h01AA60F8B8911654;
      "f": m_phase = 64'h1DC38C076704516D;
      "g": m_phase = 64'h1D60D923295482C6;
      "n": d = -67'sh71B375868D170;
      "m": d =  67'sh71B375868D170;
      "o": d = -67'sh1436A8CDF6F3;
      "p": d =  67'sh1436A8CDF6F3;
      "q": d = -67'shCA22980BA57E;
      "r": d =  67'shCA22980BA57E;
      default: begin kn = 1'b0; ea = 8'h3F; end
    endcase
    if (d != 0) begin
      v = $signed({3'b000, m_phase}) + d;
      if (v < 0) begin
        m_phase = '0; ea = 8'h21;
      end else if (v > $signed({3'b000, PH_MAX})) begin
        m_phase = PH_MAX; ea = 8'h21;
      end else begin
        m_phase = v[63:0];
      end
    end
  endtask

  // sd<0: no strobe (timeout); nd drops in WAIT_SYNC, ad in ACK
  task automatic do_cmd(input logic [7:0] b, input int sd,
                        input int rd, input int nd, input int ad,
                        input bit early, input bit hs_drop);
    bit kn;
    logic [7:0] ea;
    int u0;
    int k;
    model(b, kn, ea);
    u0 = upd_cnt;
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("busy_decode", busy, 1);
    if (early) sample_strobe = 1'b1;
    @(negedge clk);
    sample_strobe = 1'b0;
    if (!kn) begin
      chk("ack_unknown_valid", tx_valid, 1);
    end else begin
      chk("compute_no_valid", tx_valid, 0);
      @(negedge clk);
      chk("early_strobe_ignored", update, 0);
      if (sd < 0) begin
        k = 0;
        while (update !== 1'b1 && k < TIMEOUT + 100) begin
          @(negedge clk);
          k++;
        end
        chk("timeout_cycles", k, TIMEOUT);
      end else begin
        for (int i = 0; i < sd; i++) begin
          if (i % 2 == 0 && i / 2 < nd) begin
            rx_valid = 1'b1;
            rx_byte  = 8'($urandom);
            m_drops++;
          end
          @(negedge clk);
          rx_valid = 1'b0;
        end
        chk("wait_no_update", update, 0);
        sample_strobe = 1'b1;
        @(negedge clk);
        sample_strobe = 1'b0;
        chk("update_pulse", update, 1);
      end
      chk("commit_phase", phase_increment, m_phase);
      chk("commit_gain", cic_gain, m_gain);
      chk("commit_no_valid", tx_valid, 0);
      @(negedge clk);
      chk("update_one_cycle", update, 0);
      chk("ack_valid", tx_valid, 1);
    end
    chk("ack_byte", tx_byte, ea);
    for (int i = 0; i < rd; i++) begin
      if (i % 2 == 0 && i / 2 < ad) begin
        rx_valid = 1'b1;
        rx_byte  = 8'($urandom);
        m_drops++;
      end
      @(negedge clk);
      rx_valid = 1'b0;
      chk("ack_hold_valid", tx_valid, 1);
      chk("ack_hold_byte", tx_byte, ea);
    end
    tx_ready = 1'b1;
    if (hs_drop) begin
      rx_valid = 1'b1;
      rx_byte  = 8'($urandom);
      m_drops++;
    end
    @(negedge clk);
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    chk("idle_after_ack", {tx_valid, busy}, 2'b00);
    chk("update_count", upd_cnt - u0, kn ? 1 : 0);
    chk("drop_count", drop_count, drops_sat());
    chk("hold_phase", phase_increment, m_phase);
    chk("hold_gain", cic_gain, m_gain);
  endtask

  task automatic do_reset();
    rx_valid      = 1'b0;
    sample_strobe = 1'b0;
    tx_ready      = 1'b0;
    arst_n        = 1'b0;
    @(negedge clk);
    @(negedge clk);
    arst_n  = 1'b1;
    m_phase = RST_PH;
    m_gain  = '0;
    m_drops = 0;
    @(negedge clk);
  endtask

  string cmds = "0123abfgnmopqrnnoozx?";
  int u0;
  int guard;
  logic [7:0] b;
  int sd;

  initial begin
    rx_byte = '0;
    do_reset();
    chk("rst_phase", phase_increment, RST_PH);
    chk("rst_gain", cic_gain, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_byte", tx_byte, 0);
    chk("rst_drops", drop_count, 0);
    chk("rst_busy_update", {busy, update}, 2'b00);

    do_cmd("b", 7, 0, 0, 0, 1'b0, 1'b0);
    chk("preset_b", phase_increment, 64'h01AA60F8B8911654);

    do_reset();
    for (int i = 0; i < 5; i++) do_cmd("n", 2, 1, 0, 0, 1'b0, 1'b0);
    chk("five_n", phase_increment,
        64'h04CF41F212D77318 - 5 * 64'h71B375868D170);
    guard = 0;
    while (m_phase != 0 && guard < 300) begin
      do_cmd("n", 0, 0, 0, 0, 1'b0, 1'b0);
      guard++;
    end
    chk("reach_zero", phase_increment, 0);
    do_cmd("o", 1, 0, 0, 0, 1'b0, 1'b0);
    chk("o_at_zero", phase_increment, 0);

    do_cmd("z", 0, 2, 0, 0, 1'b0, 1'b0);
    do_cmd("2", 3, 0, 0, 0, 1'b0, 1'b1);
    chk("gain_two", cic_gain, 2);

    do_reset();
    do_cmd("a", 6, 4, 2, 1, 1'b0, 1'b0);
    chk("three_drops", drop_count, 3);

    do_cmd("m", -1, 0, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      b  = cmds[$urandom_range(0, cmds.len() - 1)];
      sd = $urandom_range(0, 10);
      do_cmd(b, sd, $urandom_range(0, 4), $urandom_range(0, sd / 2),
             0, 1'($urandom), 1'($urandom));
    end

    do_cmd("f", 2, 560, 0, 275, 1'b0, 1'b0);
    chk("drop_saturate", drop_count, 8'hFF);

    u0 = upd_cnt;
    rx_valid = 1'b1;
    rx_byte  = "g";
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("busy_in_wait", busy, 1);
    arst_n = 1'b0;
    #1;
    chk("mid_rst_phase", phase_increment, RST_PH);
    chk("mid_rst_gain", cic_gain, 0);
    chk("mid_rst_flags", {busy, update, tx_valid}, 3'b000);
    chk("mid_rst_drops", drop_count, 0);
    @(negedge clk);
    arst_n  = 1'b1;
    m_phase = RST_PH;
    m_gain  = '0;
    m_drops = 0;
    repeat (4) @(negedge clk);
    chk("mid_rst_no_update", upd_cnt - u0, 0);
    chk("mid_rst_hold", phase_increment, RST_PH);

    do_cmd("p", 4, 1, 1, 0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_cnt, err_cnt);
    $finish;
  end

endmodule
